mc_main_fsm: RTL
================

Name: mc_main_fsm

Overview:
- Main-decoder state machine for the multicycle MIPS core.
- Sequences the shared-memory datapath through fetch, decode, execute, memory and writeback steps.
- Sits beside the ALU decoder inside the controller. Takes the opcode from the instruction register and produces per-cycle datapath strobes and mux selects.
- Adds a memory-ready stall, a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
RETIRE_W  32  width of the retired-instruction counter

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
op  input  6  opcode field of instruction register (instr[31:26])
mem_ready  input  1  memory has completed the current access this cycle
pc_write  output  1  unconditional PC update enable
branch  output  1  conditional PC update; datapath forms pc_en = pc_write | (branch & zero)
ireg_write_enab  output  1  instruction register load
i_or_d  output  1  memory address select: 0 = PC, 1 = ALU out
mem_write_enab  output  1  memory write strobe
reg_write  output  1  register file write enable
mem_to_reg  output  1  writeback select: 1 = memory data
reg_dst  output  1  destination select: 1 = rd, 0 = rt
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = imm<<2
alu_op  output  2  00 = add, 01 = sub, 10 = decode funct
pc_src  output  2  00 = ALU result, 01 = ALU out, 10 = jump target
illegal_op  output  1  sticky: an unsupported opcode was decoded
retired  output  RETIRE_W  count of completed instructions

Behaviour:
- Decoded opcodes:
  - LW 100011
  - SW 101011
  - RTYPE 000000
  - BEQ 000100
  - ADDI 001000
  - J 000010
- Moore machine. Outputs decode from state only, except that mem_ready gates the strobes noted below.
- All outputs not listed for a state are 0.
- States, outputs and transitions:
  - FETCH: i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. pc_write = ireg_write_enab = mem_ready. Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - LW or SW -> MEMADR
    - RTYPE -> EXECUTE
    - BEQ -> BRANCH
    - ADDI -> ADDIEX
    - J -> JUMP
    - any other opcode -> FETCH, and set illegal_op.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW -> MEMRD, SW -> MEMWR.
  - MEMRD: i_or_d=1. Waits for mem_ready, then -> MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
  - MEMWR: i_or_d=1, mem_write_enab=1 for every cycle of the state. Waits for mem_ready, then -> FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. -> ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
  - JUMP: pc_src=10, pc_write=1. -> FETCH.
- op is sampled in DECODE and MEMADR only. The IR is stable between fetches.
- Cycle counts with mem_ready held at 1:
  - LW 5
  - SW 4
  - RTYPE 4
  - ADDI 4
  - BEQ 3
  - J 3
- retired counter:
  - Increments by 1 on the clock edge that moves the FSM into FETCH from MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, or from MEMWR with mem_ready.
  - Does not increment on the illegal-opcode path DECODE -> FETCH.
  - Wraps modulo 2^RETIRE_W with no flag.
- illegal_op sets on the DECODE edge that sees an unsupported opcode. Only reset clears it.
- Reset, sampled at a rising edge and taking priority over every transition, including one mid-instruction or mid-wait:
  - state = FETCH
  - retired = 0
  - illegal_op = 0
- While reset is high:
  - pc_write, branch, ireg_write_enab, mem_write_enab and reg_write are forced to 0.
  - Mux selects show their FETCH values: i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, mem_to_reg=0, reg_dst=0.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

Test Plan:
1. Reset for 2 cycles, then release with mem_ready=1 and op=LW -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_write=1 and mem_to_reg=1 only in MEMWB; retired=1 after 5 cycles.
2. Run SW, RTYPE, ADDI, BEQ, J back to back with mem_ready=1 -> durations 4, 4, 4, 3, 3 cycles; BEQ asserts branch=1 with pc_src=01; J asserts pc_write=1 with pc_src=10; retired=5.
3. LW with mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEMRD -> pc_write and ireg_write_enab stay 0 until the ready cycle; total latency 10 cycles; retired increments once.
4. SW with mem_ready low for 4 MEMWR cycles -> mem_write_enab=1 for all 5 MEMWR cycles; then FETCH.
5. op=111111 in DECODE -> next state FETCH; illegal_op=1 and stays 1 through a following ADDI; retired unchanged by the illegal opcode, +1 after the ADDI.
6. Assert reset while in MEMRD with mem_ready=0 -> next state FETCH, retired=0, illegal_op=0, all write strobes 0 during reset. With RETIRE_W=4, run 17 J instructions -> retired=1 (wrap).

Source files
------------

// File: rtl/mc_main_fsm.sv
// Main-decoder state machine for the multicycle MIPS controller: walks the shared-memory
// datapath through fetch/decode/execute/memory/writeback, with memory stalls and retire count.
module mc_main_fsm #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch,
  output logic                ireg_write_enab,
  output logic                i_or_d,
  output logic                mem_write_enab,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  state_t              r_state;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:   if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            default: begin
              r_state   <= S_FETCH;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:  r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR: begin
          if (mem_ready) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + RETIRE_W'(1);
          end
        end
        S_EXECUTE: r_state <= S_ALUWB;
        S_ADDIEX:  r_state <= S_ADDIWB;
        // Every other state is a final step that retires its instruction.
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + RETIRE_W'(1);
        end
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from state; FETCH strobes wait on mem_ready, and reset parks
  // everything at idle FETCH selects with no write strobes.
  always_comb begin
    pc_write        = 1'b0;
    branch          = 1'b0;
    ireg_write_enab = 1'b0;
    i_or_d          = 1'b0;
    mem_write_enab  = 1'b0;
    reg_write       = 1'b0;
    mem_to_reg      = 1'b0;
    reg_dst         = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_src          = 2'b00;
    if (reset) begin
      alu_src_b = 2'b01;
    end else begin
      case (r_state)
        S_FETCH: begin
          alu_src_b       = 2'b01;
          pc_write        = mem_ready;
          ireg_write_enab = mem_ready;
        end
        S_DECODE:  alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD:   i_or_d = 1'b1;
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          i_or_d         = 1'b1;
          mem_write_enab = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          branch    = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB:  reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign retired    = r_retired;
  assign illegal_op = r_illegal;

endmodule
